// File: rtl/hazard_scoreboard_pkg.sv
// Shared slot layout, default latencies and the one-hot destination decode
// used by the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned GPR_N       = 32;
  localparam int unsigned DST_W       = 5;
  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 6;

  typedef struct packed {
    logic             v;
    logic [DST_W-1:0] d;
  } slot_t;

  // Pending-write mask of one slot; empty slots contribute nothing.
  function automatic logic [GPR_N-1:0] dst_mask(input slot_t s);
    return s.v ? (GPR_N'(1) << s.d) : '0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_occupancy_counter.sv
// Multi-cycle MULT/DIV occupancy counter: loads the op latency on accept and
// counts down, keeping EX busy while the count is non-zero.
module md_occupancy_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             is_mul,
  input  logic             is_div,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  logic [CNT_W-1:0] count_nxt;

  // DIV wins when both op flags are set.
  always_comb begin
    count_nxt = count;
    if (accept && is_div) begin
      count_nxt = CNT_W'(DIV_LAT - 1);
    end else if (accept && is_mul) begin
      count_nxt = CNT_W'(MUL_LAT - 1);
    end else if (count != '0) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // busy is registered from the next count so it always equals (count != 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_nxt;
      busy  <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks pending GPR writes in the EX/MEM/WB slots and publishes per-stage
// one-hot destination masks for the decode-stage RAW stall.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IssueValid,
  input  logic             IssueWb,
  input  logic [DST_W-1:0] IssueDst,
  input  logic             IssueMul,
  input  logic             IssueDiv,
  input  logic             Flush,
  output logic [GPR_N-1:0] RdEx,
  output logic [GPR_N-1:0] RdMem,
  output logic [GPR_N-1:0] RdWb,
  output logic             ExBusy,
  output logic             WbValid,
  output logic [DST_W-1:0] WbDst,
  output logic [CNT_W-1:0] MdCount
);

  slot_t ex, mem, wb;
  slot_t ex_nxt, mem_nxt;
  logic  accept_c, wr_c;

  assign accept_c = IssueValid & ~Flush & ~ExBusy;
  assign wr_c     = accept_c & IssueWb & (IssueDst != '0);

  md_occupancy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_cnt (
    .clk    (Clk),
    .rst_n  (Reset),
    .accept (accept_c),
    .is_mul (IssueMul),
    .is_div (IssueDiv),
    .count  (MdCount),
    .busy   (ExBusy)
  );

  // While a multi-cycle op holds EX, EX freezes and MEM receives bubbles.
  always_comb begin
    ex_nxt  = ex;
    mem_nxt = ex;
    if (ExBusy) begin
      mem_nxt = '0;
    end else begin
      ex_nxt = slot_t'{v: wr_c, d: IssueDst};
    end
  end

  // Masks are registered alongside the slots from the same next-state values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex      <= '0;
      mem     <= '0;
      wb      <= '0;
      RdEx    <= '0;
      RdMem   <= '0;
      RdWb    <= '0;
      WbValid <= 1'b0;
      WbDst   <= '0;
    end else begin
      ex      <= ex_nxt;
      mem     <= mem_nxt;
      wb      <= mem;
      RdEx    <= dst_mask(ex_nxt);
      RdMem   <= dst_mask(mem_nxt);
      RdWb    <= dst_mask(mem);
      WbValid <= mem.v;
      WbDst   <= mem.d;
    end
  end

  logic unused_wb;
  assign unused_wb = ^wb;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks pending register writes for the instruction held in each of the EX, MEM and WB pipeline slots.
- Drives the per-stage 32-bit pending-destination masks (RdEx, RdMem, RdWb) that the decode stage uses to generate its RAW-hazard stall.
- Sequences multi-cycle MULT/DIV occupancy of EX: holds the EX slot and inserts bubbles into MEM until the operation completes.
- Sits beside the decode stage and is fed by its issue outputs and by the branch-resolution signal.

Parameters:
MUL_LAT, 4, total EX-occupancy cycles for MULT/MULTU (legal range 1..63)
DIV_LAT, 32, total EX-occupancy cycles for DIV/DIVU (legal range 1..63)
CNT_W, 6, width of the multi-cycle counter; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
IssueValid  in  1  decode presents a non-bubble instruction, entering EX at the next edge
IssueWb  in  1  issued instruction writes a GPR (decode Control[31])
IssueDst  in  5  destination GPR index of the issued instruction
IssueMul  in  1  issued instruction is MULT/MULTU
IssueDiv  in  1  issued instruction is DIV/DIVU
Flush  in  1  branch taken; kills the instruction currently being issued
RdEx  out  32  one-hot pending-write mask for the EX slot
RdMem  out  32  one-hot pending-write mask for the MEM slot
RdWb  out  32  one-hot pending-write mask for the WB slot
ExBusy  out  1  multi-cycle op occupies EX; decode must not issue
WbValid  out  1  WB slot holds a pending GPR write
WbDst  out  5  destination of the WB slot
MdCount  out  CNT_W  remaining multi-cycle count, for debug

Behaviour:
- Reset is asynchronous and active-low. While Reset=0: all slot valids=0, all dsts=0, counter=0, so all Rd* masks=0, ExBusy=0, WbValid=0, WbDst=0, MdCount=0.
- Each slot s in {ex, mem, wb} holds {v_s, d_s[4:0]}. Mask output: Rd_s = v_s ? (32'b1 << d_s) : 0. All outputs are derived from registered state only, with no combinational path from any input.
- accept = IssueValid & ~Flush & ~ExBusy.
- wr = accept & IssueWb & (IssueDst != 0). Register 0 never produces a mask bit.
- Normal cycle (ExBusy=0): ex <= {wr, IssueDst}; mem <= ex; wb <= mem.
- Busy cycle (ExBusy=1): ex holds its value; mem <= {0, 0} (bubble); wb <= mem.
- WB slot retires every cycle. WbValid = v_wb and WbDst = d_wb.
- Counter:
  - On accept & IssueDiv: counter <= DIV_LAT-1.
  - Else on accept & IssueMul: counter <= MUL_LAT-1.
  - Else if counter != 0: counter <= counter-1.
  - IssueDiv has priority if both IssueMul and IssueDiv are asserted.
  - ExBusy = (counter != 0).
  - A latency of 1 gives no busy cycles.
- Occupancy timing: a MUL issued at edge N gives ExBusy=1 for edges N+1 .. N+MUL_LAT-1. The EX slot advances at the first edge where ExBusy=0.
- IssueValid while ExBusy=1: the instruction is ignored and no state changes from it. Decode is required to hold it; the bench flags this as a protocol assertion.
- Flush has priority over IssueValid. The killed instruction never appears in any mask. Flush does not affect slots already in EX/MEM/WB, and does not cancel a running counter.
- Same dst in multiple slots is legal: each mask independently shows the bit.
- Reset asserted mid multi-cycle op clears everything immediately. The first issue after reset release is accepted.

Decomposition:
- Shared include (alongside instruction_set.vh): slot field widths, and the MUL_LAT/DIV_LAT defaults as `defines.
- One natural sub-module, md_occupancy_counter, containing the counter, load priority and ExBusy generation.
- The slot shift and mask decode stay in the top level.

Test Plan:
1. Reset=0 with random inputs -> all outputs 0; after release, issue ADD dst=5 wb=1 -> RdEx=0x20, next cycle RdMem=0x20, next RdWb=0x20 with WbValid=1 and WbDst=5, next cycle all 0.
2. Issue dst=0 with wb=1, and separately dst=7 with wb=0 -> all masks remain 0 through all three stages.
3. MUL (MUL_LAT=4) issued, followed by ADD dst=3 held on IssueValid -> ExBusy=1 for 3 cycles; the ADD is ignored and RdMem shows bubbles; the ADD is accepted on the first cycle ExBusy=0, and RdEx=0x8 one cycle later.
4. IssueValid with dst=9 and Flush=1 in the same cycle -> RdEx=0 next cycle; an older instruction dst=4 already in EX proceeds to RdMem=0x10 unaffected.
5. DIV issued (DIV_LAT=32), then Reset pulsed low while MdCount=20 -> MdCount=0, ExBusy=0 and masks 0 immediately (asynchronously); a post-reset issue of dst=2 gives RdEx=0x4.
6. IssueMul=1 and IssueDiv=1 together -> MdCount loads 31 and ExBusy lasts 31 cycles.
